// File: rtl/complex_mul_param_if.sv
// complex_mul_param_if: I/Q-interleaved operand, result and status bundle for complex_mul_param.
interface complex_mul_param_if #(parameter int DW = 18, parameter int OW = 18);
  logic gate_in, iq, conj, clr;
  logic signed [DW-1:0] x, y;
  logic signed [OW-1:0] z;
  logic signed [2*DW:0] z_all;
  logic z_iq, gate_out, sat_out, sat_sticky, pair_err;
  logic [15:0] sat_cnt;
  modport master(output gate_in, iq, conj, x, y, clr,
                 input z, z_all, z_iq, gate_out, sat_out, sat_sticky, pair_err, sat_cnt);
  modport slave(input gate_in, iq, conj, x, y, clr,
                output z, z_all, z_iq, gate_out, sat_out, sat_sticky, pair_err, sat_cnt);
endinterface

// File: rtl/complex_mul_param.sv
// complex_mul_param: IQ-serialized complex multiplier with two multipliers, rounding and saturation.
// Defining CMUL_SAT_CNT_EN enables the saturation event counter sat_cnt.
module complex_mul_param #(
  parameter int DW = 18,
  parameter int OW = 18,
  parameter int ROUND = 1
) (
  input logic clk,
  input logic rst,
  complex_mul_param_if.slave bus
);
  localparam int PW = 2*DW;
  localparam int SW = PW+1;
  localparam int RW = SW+1;
  localparam int K = 2*DW-1-OW;
  localparam logic signed [RW-1:0] RND = ROUND != 0 ? RW'(1) << (K-1) : '0;
  localparam logic signed [RW-1:0] ZMAX = (RW'(1) << (OW-1)) - RW'(1);
  localparam logic signed [RW-1:0] ZMIN = ~ZMAX;
  logic signed [DW-1:0] x1, x2, x3, y1, y2, y3;
  logic [2:0] qd, gd, cd;
  logic signed [PW-1:0] m1, m2;
  logic signed [SW-1:0] sum;
  logic signed [RW-1:0] r;
  logic sat_c, err_c, pv;
  // qd[2] high means m1/m2 hold a*c and b*d; low means a*d and b*c
  always_comb begin
    sum = qd[2] ? (cd[2] ? SW'(m1) + SW'(m2) : SW'(m1) - SW'(m2))
                : (cd[2] ? SW'(m2) - SW'(m1) : SW'(m1) + SW'(m2));
    r = (RW'(sum) + RND) >>> K;
    sat_c = r > ZMAX || r < ZMIN;
    err_c = bus.gate_in && (bus.iq ? pv : !pv);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {x1, x2, x3, y1, y2, y3} <= '0;
      {qd, gd, cd, pv} <= '0;
      {m1, m2} <= '0;
      bus.z <= '0;
      bus.z_all <= '0;
      {bus.z_iq, bus.gate_out, bus.sat_out, bus.sat_sticky, bus.pair_err} <= '0;
    end else begin
      {x3, x2, x1} <= {x2, x1, bus.x};
      {y3, y2, y1} <= {y2, y1, bus.y};
      qd <= {qd[1:0], bus.iq};
      gd <= {gd[1:0], bus.gate_in};
      cd <= {cd[1:0], bus.iq ? bus.conj : cd[0]};
      m1 <= PW'(qd[1] ? x2 : x3) * PW'(y2);
      m2 <= PW'(qd[1] ? x1 : x2) * PW'(qd[1] ? y1 : y3);
      bus.z_all <= sum;
      bus.z <= sat_c ? (r[RW-1] ? ZMIN[OW-1:0] : ZMAX[OW-1:0]) : r[OW-1:0];
      bus.sat_out <= sat_c;
      bus.z_iq <= qd[2];
      bus.gate_out <= gd[2];
      bus.sat_sticky <= sat_c | (bus.sat_sticky & ~bus.clr);
      pv <= bus.gate_in & bus.iq;
      bus.pair_err <= err_c | (bus.pair_err & ~bus.clr);
    end
`ifdef CMUL_SAT_CNT_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) bus.sat_cnt <= '0;
    else if (bus.clr) bus.sat_cnt <= 16'(sat_c);
    else if (sat_c && bus.sat_cnt != 16'hFFFF) bus.sat_cnt <= bus.sat_cnt + 16'd1;
`else
  assign bus.sat_cnt = '0;
`endif
endmodule

// File: tb/tb_complex_mul_param.sv
// tb_complex_mul_param: directed and randomized checks of complex_mul_param against a plain-arithmetic model.
module tb_complex_mul_param;
  localparam int DW = 18;
  localparam int OW = 18;
  localparam int ROUND = 1;
  localparam int K = 2*DW-1-OW;
  localparam longint ZMAX = (longint'(1) << (OW-1)) - 1;
  localparam longint ZMIN = -ZMAX - 1;
  localparam longint FSP = (longint'(1) << (DW-1)) - 1;
  localparam longint FSN = -(longint'(1) << (DW-1));
`ifdef CMUL_SAT_CNT_EN
  localparam bit CNT = 1;
`else
  localparam bit CNT = 0;
`endif
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  complex_mul_param_if #(.DW(DW), .OW(OW)) bus();
  complex_mul_param #(.DW(DW), .OW(OW), .ROUND(ROUND)) dut(.clk(clk), .rst(rst), .bus(bus.slave));
  int ncmp = 0, nerr = 0, cyc = 0;
  bit vc[2048], vd[2048], eg[2048], eq[2048], es[2048];
  longint ez[2048], ea[2048];
  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d (step %0d)", tag, obs, exp, cyc);
    end
  endtask
  function automatic longint shr(input longint s);
    return (s + (ROUND != 0 ? (longint'(1) << (K-1)) : 0)) >>> K;
  endfunction
  function automatic longint clamp(input longint v);
    return v > ZMAX ? ZMAX : (v < ZMIN ? ZMIN : v);
  endfunction
  task automatic expect_sum(input int idx, input longint s);
    vd[idx] = 1;
    ea[idx] = s;
    ez[idx] = clamp(shr(s));
    es[idx] = clamp(shr(s)) != shr(s);
  endtask
  task automatic step(input bit g, input bit q, input bit cj, input longint xv, input longint yv, input bit cl);
    bus.gate_in = g; bus.iq = q; bus.conj = cj; bus.clr = cl;
    bus.x = DW'(xv); bus.y = DW'(yv);
    vc[cyc+3] = 1; eg[cyc+3] = g; eq[cyc+3] = q;
    @(posedge clk); #1;
    if (vc[cyc]) begin
      chk("gate_out", bus.gate_out, eg[cyc]);
      chk("z_iq", bus.z_iq, eq[cyc]);
    end
    if (vd[cyc]) begin
      chk("z", bus.z, ez[cyc]);
      chk("z_all", bus.z_all, ea[cyc]);
      chk("sat_out", bus.sat_out, es[cyc]);
    end
    cyc++;
  endtask
  task automatic gap(input bit cl);
    step(0, 0, 0, 0, 0, cl);
  endtask
  task automatic pair(input longint a, input longint b, input longint c, input longint d, input bit cj);
    expect_sum(cyc+3, cj ? a*c + b*d : a*c - b*d);
    expect_sum(cyc+4, cj ? b*c - a*d : a*d + b*c);
    step(1, 1, cj, a, c, 0);
    step(1, 0, !cj, b, d, 0);
  endtask
  task automatic zero_chk(input string tag);
    chk({tag, ".z"}, bus.z, 0);
    chk({tag, ".z_all"}, bus.z_all, 0);
    chk({tag, ".gate_out"}, bus.gate_out, 0);
    chk({tag, ".z_iq"}, bus.z_iq, 0);
    chk({tag, ".sat_out"}, bus.sat_out, 0);
    chk({tag, ".sat_sticky"}, bus.sat_sticky, 0);
    chk({tag, ".pair_err"}, bus.pair_err, 0);
    chk({tag, ".sat_cnt"}, bus.sat_cnt, 0);
  endtask
  task automatic mark_zero();
    for (int i = 0; i < 3; i++) begin
      vc[cyc+i] = 1; eg[cyc+i] = 0; eq[cyc+i] = 0;
      vd[cyc+i] = 1; ez[cyc+i] = 0; ea[cyc+i] = 0; es[cyc+i] = 0;
    end
  endtask
  task automatic rst_pulse();
    bus.gate_in = 0; bus.iq = 0; bus.clr = 0;
    rst = 1;
    #1 zero_chk("async_rst");
    #2 rst = 0;
    mark_zero();
  endtask
  function automatic longint rv();
    if ($urandom_range(0, 7) == 0) return $urandom_range(0, 1) != 0 ? FSN : FSP;
    return longint'($urandom_range(0, (1 << DW) - 1)) + FSN;
  endfunction
  initial begin
    {bus.gate_in, bus.iq, bus.conj, bus.clr} = '0;
    bus.x = '0; bus.y = '0;
    repeat (2) @(posedge clk);
    #1 zero_chk("reset");
    rst = 0;
    mark_zero();
    pair(65536, 65536, 65536, -65536, 0);
    pair(65536, 65536, 65536, -65536, 1);
    repeat (5) gap(0);
    chk("sticky_no_sat", bus.sat_sticky, 0);
    pair(FSP, FSP, FSP, -FSP, 0);
    repeat (5) gap(0);
    chk("sat_sticky", bus.sat_sticky, 1);
    chk("sat_cnt", bus.sat_cnt, CNT ? 1 : 0);
    gap(1);
    chk("sticky_clr", bus.sat_sticky, 0);
    chk("cnt_clr", bus.sat_cnt, 0);
    pair(FSP, FSP, FSP, -FSP, 0);
    gap(0);
    gap(1);
    chk("sticky_clr_vs_event", bus.sat_sticky, 1);
    chk("cnt_clr_vs_event", bus.sat_cnt, CNT ? 1 : 0);
    pair(FSN, 0, FSN, 0, 0);
    pair(FSN, 0, FSP, 0, 0);
    pair(1, 0, 65536, 0, 0);
    pair(FSN, FSN, FSN, FSN, 1);
    for (int i = 0; i < 150; i++) begin
      pair(rv(), rv(), rv(), rv(), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) gap(0);
    end
    repeat (5) gap(0);
    chk("no_pair_err", bus.pair_err, 0);
    gap(1);
    step(1, 1, 0, 0, 0, 0);
    chk("single_i_ok", bus.pair_err, 0);
    step(1, 1, 0, 0, 0, 0);
    chk("double_i_err", bus.pair_err, 1);
    gap(0);
    chk("err_sticky", bus.pair_err, 1);
    gap(1);
    chk("err_clr", bus.pair_err, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("lone_q_err", bus.pair_err, 1);
    gap(1);
    pair(65536, 65536, 65536, -65536, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    chk("pre_rst_gate", bus.gate_out, 1);
    chk("pre_rst_err", bus.pair_err, 1);
    rst_pulse();
    pair(65536, 65536, 65536, -65536, 0);
    pair(rv(), rv(), rv(), rv(), 0);
    repeat (6) gap(0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
